// File: rtl/clk_div_bank.sv
// Bank of NCH independent runtime-programmable clock dividers / tick generators.
// Divisor and mode changes are deferred to the period boundary so no short or glitched period is produced.
module clk_div_bank #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = 27,
    parameter int unsigned DEF_DIV  = 50_000_000,
    parameter logic        DEF_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    load,
    input  logic [NCH*CW-1:0] div,
    input  logic [NCH-1:0]    mode,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    tick
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] div_q, div_d;
        logic [CW-1:0] pdiv_q, pdiv_d;
        logic [CW-1:0] div_in;
        logic          mode_q, mode_d;
        logic          pmode_q, pmode_d;
        logic          pv_q, pv_d;
        logic          co_q, co_d;
        logic          tk_q, tk_d;
        logic          parked;
        logic          tc;

        assign div_in = div[g*CW +: CW];

        // Next-state: immediate load when idle, deferred load otherwise, counting and output shaping
        always_comb begin
            cnt_d   = cnt_q;
            div_d   = div_q;
            mode_d  = mode_q;
            pdiv_d  = pdiv_q;
            pmode_d = pmode_q;
            pv_d    = pv_q;
            co_d    = co_q;
            tk_d    = 1'b0;
            parked  = (div_q == '0);
            tc      = en[g] && !parked && (cnt_q == div_q - CW'(1));

            if (load[g] && (!en[g] || parked)) begin
                div_d  = div_in;
                mode_d = mode[g];
                cnt_d  = '0;
                pv_d   = 1'b0;
                co_d   = 1'b0;
            end else if (parked) begin
                cnt_d = '0;
                co_d  = 1'b0;
            end else if (en[g]) begin
                if (tc) begin
                    cnt_d = '0;
                    tk_d  = 1'b1;
                    pv_d  = 1'b0;
                    if (load[g]) begin
                        div_d  = div_in;
                        mode_d = mode[g];
                    end else if (pv_q) begin
                        div_d  = pdiv_q;
                        mode_d = pmode_q;
                    end
                    // Output follows the mode that governs the new period
                    co_d = mode_d ? 1'b1 : ~co_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (mode_q) begin
                        co_d = 1'b0;
                    end
                    if (load[g]) begin
                        pdiv_d  = div_in;
                        pmode_d = mode[g];
                        pv_d    = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q   <= '0;
                div_q   <= CW'(DEF_DIV);
                mode_q  <= DEF_MODE;
                pdiv_q  <= '0;
                pmode_q <= 1'b0;
                pv_q    <= 1'b0;
                co_q    <= 1'b0;
                tk_q    <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                mode_q  <= mode_d;
                pdiv_q  <= pdiv_d;
                pmode_q <= pmode_d;
                pv_q    <= pv_d;
                co_q    <= co_d;
                tk_q    <= tk_d;
            end
        end

        assign clk_out[g] = co_q;
        assign tick[g]    = tk_q;
    end

endmodule
